// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream and ram-port bundle for ram_fifo_ctrl.
// slave = FIFO controller side; master = upstream, downstream and ram side.
interface ram_fifo_ctrl_if #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
);
  logic               push_valid;
  logic               push_ready;
  logic [D_WIDTH-1:0] push_data;
  logic               pop_valid;
  logic               pop_ready;
  logic [D_WIDTH-1:0] pop_data;
  logic [A_WIDTH-1:0] ram_address_write;
  logic [D_WIDTH-1:0] ram_data_write;
  logic               ram_write_enable;
  logic [A_WIDTH-1:0] ram_address_read;
  logic [D_WIDTH-1:0] ram_data_read;

  modport slave (
    input  push_valid, push_data, pop_ready, ram_data_read,
    output push_ready, pop_valid, pop_data,
    output ram_address_write, ram_data_write, ram_write_enable, ram_address_read
  );

  modport master (
    output push_valid, push_data, pop_ready, ram_data_read,
    input  push_ready, pop_valid, pop_data,
    input  ram_address_write, ram_data_write, ram_write_enable, ram_address_read
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a 1W/1R ram with registered read data; hides read latency and write/read hazard.
// Optional RAM_FIFO_LEVEL_EN adds registered fill_level and almost_full outputs.
module ram_fifo_ctrl #(
  parameter int D_WIDTH  = 16,
  parameter int A_WIDTH  = 5
`ifdef RAM_FIFO_LEVEL_EN
  ,
  parameter int AF_LEVEL = 28
`endif
) (
  input  logic              clk,
  input  logic              reset,
  ram_fifo_ctrl_if.slave    bus
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [A_WIDTH:0]  fill_level,
  output logic              almost_full
`endif
);

  localparam int CW = A_WIDTH + 1;
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_ONE  = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_FULL = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH-1:0] PTR_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};

  logic [A_WIDTH-1:0] wr_ptr_r;
  logic [A_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_next_s;
  logic               pop_valid_r;
  logic               pop_valid_next_s;
  logic               push_ready_s;
  logic               push_fire_s;
  logic               pop_fire_s;
  logic [A_WIDTH-1:0] rd_addr_s;
  logic [D_WIDTH-1:0] head_data_s;

  // Handshake qualification and read-address lookahead
  always_comb begin
    push_ready_s = 1'b0;
    rd_addr_s    = rd_ptr_r;
    if (reset) begin
      push_ready_s = 1'b0;
    end else begin
      push_ready_s = (count_r != CNT_FULL);
    end
    push_fire_s = bus.push_valid & push_ready_s;
    pop_fire_s  = pop_valid_r & bus.pop_ready;
    if (pop_fire_s) begin
      rd_addr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_addr_s = rd_ptr_r;
    end
  end

  // Occupancy update and head visibility
  always_comb begin
    count_next_s     = count_r;
    pop_valid_next_s = 1'b0;
    case ({push_fire_s, pop_fire_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    // Only entries already in the ram before this edge can be read back by it;
    // a word pushed on this edge is never the one loaded now.
    if (pop_fire_s) begin
      pop_valid_next_s = (count_r > CNT_ONE);
    end else begin
      pop_valid_next_s = (count_r != CNT_ZERO);
    end
  end

  // Pointer, count and pop_valid state
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {A_WIDTH{1'b0}};
      rd_ptr_r    <= {A_WIDTH{1'b0}};
      count_r     <= CNT_ZERO;
      pop_valid_r <= 1'b0;
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_next_s;
      pop_valid_r <= pop_valid_next_s;
    end
  end

  assign head_data_s           = bus.ram_data_read;
  assign bus.push_ready        = push_ready_s;
  assign bus.pop_valid         = pop_valid_r;
  assign bus.pop_data          = head_data_s;
  assign bus.ram_write_enable  = push_fire_s;
  assign bus.ram_address_write = wr_ptr_r;
  assign bus.ram_data_write    = bus.push_data;
  assign bus.ram_address_read  = rd_addr_s;

`ifdef RAM_FIFO_LEVEL_EN
  localparam logic [CW-1:0] CNT_AF = CW'(AF_LEVEL);

  logic [CW-1:0] fill_level_r;
  logic          almost_full_r;

  // Registered occupancy reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_level_r  <= CNT_ZERO;
      almost_full_r <= 1'b0;
    end else begin
      fill_level_r  <= count_next_s;
      almost_full_r <= (count_next_s >= CNT_AF);
    end
  end

  assign fill_level  = fill_level_r;
  assign almost_full = almost_full_r;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural ram and a queue-based reference model.
module tb_ram_fifo_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ram_fifo_ctrl_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

`ifdef RAM_FIFO_LEVEL_EN
  logic [AW:0] fill_level;
  logic        almost_full;
`endif

  ram_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .fill_level  (fill_level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  // 1W/1R ram: registered read, old data returned on same-edge collision
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address_write] <= bus.ram_data_write;
    bus.ram_data_read <= mem[bus.ram_address_read];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            w;
  } ent_t;

  ent_t q[$];
  int   cyc      = 0;
  int   wr_cnt   = 0;
  int   rd_cnt   = 0;
  int   n_popped = 0;
  bit   chk_en   = 1'b0;
  int   n_vec    = 0;
  int   n_miss   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word is poppable once it is head and was written two or more cycles ago
  always @(negedge clk) begin : cmp
    bit pv;
    bit pr;
    bit wf;
    bit pf;
    pv = (q.size() > 0) && (q[0].w <= cyc - 2);
    pr = !reset && (q.size() < DEPTH);
    wf = bus.push_valid && pr;
    pf = pv && bus.pop_ready;
    if (chk_en) begin
      chk("m_push_ready", 32'(bus.push_ready), 32'(pr));
      chk("m_pop_valid", 32'(bus.pop_valid), 32'(pv));
      chk("m_ram_we", 32'(bus.ram_write_enable), 32'(wf));
      chk("m_ram_addr_rd", 32'(bus.ram_address_read), 32'((rd_cnt + int'(pf)) % DEPTH));
      if (pv) chk("m_pop_data", 32'(bus.pop_data), 32'(q[0].data));
      if (wf) begin
        chk("m_ram_addr_wr", 32'(bus.ram_address_write), 32'(wr_cnt % DEPTH));
        chk("m_ram_data_wr", 32'(bus.ram_data_write), 32'(bus.push_data));
      end
`ifdef RAM_FIFO_LEVEL_EN
      chk("m_fill_level", 32'(fill_level), 32'(q.size()));
      chk("m_almost_full", 32'(almost_full), 32'(q.size() >= 28));
`endif
    end
    if (reset) begin
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      if (pf) begin
        void'(q.pop_front());
        rd_cnt++;
        n_popped++;
      end
      if (wf) begin
        q.push_back('{data: bus.push_data, w: cyc});
        wr_cnt++;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int guard;
    int start;
    bus.push_valid = 1'b0;
    bus.push_data  = 16'h0000;
    bus.pop_ready  = 1'b0;
    reset          = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("idle_push_ready", 32'(bus.push_ready), 32'd1);
    chk("idle_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("idle_ram_we", 32'(bus.ram_write_enable), 32'd0);
    chk("idle_addr_rd", 32'(bus.ram_address_read), 32'd0);
    step();

    // single push latency
    bus.push_valid = 1'b1;
    bus.push_data  = 16'hA5A5;
    #1;
    chk("a5_ram_we", 32'(bus.ram_write_enable), 32'd1);
    chk("a5_addr_wr", 32'(bus.ram_address_write), 32'd0);
    step();
    bus.push_valid = 1'b0;
    #1;
    chk("a5_t1_pop_valid", 32'(bus.pop_valid), 32'd0);
    step();
    #1;
    chk("a5_t2_pop_valid", 32'(bus.pop_valid), 32'd1);
    chk("a5_t2_pop_data", 32'(bus.pop_data), 32'h0000A5A5);
    bus.pop_ready = 1'b1;
    step();
    bus.pop_ready = 1'b0;
    #1;
    chk("a5_drained", 32'(bus.pop_valid), 32'd0);

    // fill to full, then drain back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 16'(i);
      step();
    end
    bus.push_data = 16'h0021;
    #1;
    chk("full_push_ready", 32'(bus.push_ready), 32'd0);
    chk("full_no_write", 32'(bus.ram_write_enable), 32'd0);
    step();
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("full_pop_valid", 32'(bus.pop_valid), 32'd1);
      chk("full_pop_data", 32'(bus.pop_data), 32'(i));
      step();
    end
    #1;
    chk("full_empty_after", 32'(bus.pop_valid), 32'd0);
    bus.pop_ready = 1'b0;
    step();

    // 100-word stream with both sides always ready
    start = n_popped;
    idx   = 0;
    guard = 0;
    bus.push_valid = 1'b1;
    bus.pop_ready  = 1'b1;
    while (idx < 100 && guard < 1000) begin
      bus.push_data = 16'h0100 + 16'(idx);
      #1;
      if (bus.push_ready) idx++;
      guard++;
      step();
    end
    bus.push_valid = 1'b0;
    guard = 0;
    while ((n_popped - start) < 100 && guard < 200) begin
      guard++;
      step();
    end
    chk("stream_pushed", 32'(idx), 32'd100);
    chk("stream_popped", 32'(n_popped - start), 32'd100);
    bus.pop_ready = 1'b0;
    step();
    #1;
    chk("stream_empty", 32'(bus.pop_valid), 32'd0);

    // reset with 10 words buffered; push during reset is dropped
    for (int i = 0; i < 10; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 16'h0050 + 16'(i);
      step();
    end
    bus.push_data = 16'hDEAD;
    reset         = 1'b1;
    #1;
    chk("rst_push_ready", 32'(bus.push_ready), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_write_enable), 32'd0);
    step();
    reset          = 1'b0;
    bus.push_valid = 1'b0;
    #1;
    chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst_push_ready_after", 32'(bus.push_ready), 32'd1);
    bus.push_valid = 1'b1;
    bus.push_data  = 16'h1234;
    step();
    bus.push_valid = 1'b0;
    step();
    #1;
    chk("rst_first_valid", 32'(bus.pop_valid), 32'd1);
    chk("rst_first_data", 32'(bus.pop_data), 32'h00001234);
    bus.pop_ready = 1'b1;
    step();
    bus.pop_ready = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.pop_valid), 32'd0);

`ifdef RAM_FIFO_LEVEL_EN
    // level reporting around the almost_full threshold
    for (int i = 0; i < 28; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 16'h0200 + 16'(i);
      step();
    end
    bus.push_valid = 1'b0;
    #1;
    chk("lvl_fill_28", 32'(fill_level), 32'd28);
    chk("lvl_af_28", 32'(almost_full), 32'd1);
    bus.pop_ready = 1'b1;
    step();
    bus.pop_ready = 1'b0;
    #1;
    chk("lvl_fill_27", 32'(fill_level), 32'd27);
    chk("lvl_af_27", 32'(almost_full), 32'd0);
`endif

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
